// File: rtl/hex_uart_dumper.sv
// Serialises a captured 32-bit word as 8 uppercase ASCII hex characters
// (optionally followed by CR LF) on an 8N1 UART line.
module hex_uart_dumper #(
  parameter int CLKS_PER_BIT = 868,
  parameter bit SEND_CRLF    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inp,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        tx
);

  localparam int             CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]     LAST_CH = SEND_CRLF ? 4'd9 : 4'd7;

  typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bitn, bitn_n;
  logic [3:0]    chr, chr_n;
  logic [31:0]   cap, cap_n;
  logic [7:0]    shreg, shreg_n;
  logic          tx_n, busy_n, done_n;

  // Character k of the line: hex digits MSB nibble first, then CR, LF.
  function automatic logic [7:0] enc(input logic [31:0] v, input logic [3:0] k);
    logic [3:0] nib;
    nib = 4'(v >> (5'd28 - {k[2:0], 2'b00}));
    if (k == 4'd8)        enc = 8'h0D;
    else if (k == 4'd9)   enc = 8'h0A;
    else if (nib < 4'd10) enc = 8'h30 + {4'h0, nib};
    else                  enc = 8'h37 + {4'h0, nib};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      bitn  <= '0;
      chr   <= '0;
      cap   <= '0;
      shreg <= '0;
      tx    <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bitn  <= bitn_n;
      chr   <= chr_n;
      cap   <= cap_n;
      shreg <= shreg_n;
      tx    <= tx_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bitn_n  = bitn;
    chr_n   = chr;
    cap_n   = cap;
    shreg_n = shreg;
    tx_n    = tx;
    busy_n  = busy;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (start) begin
          state_n = START_BIT;
          cap_n   = inp;
          chr_n   = '0;
          cnt_n   = '0;
          shreg_n = enc(inp, 4'd0);
          tx_n    = 1'b0;
          busy_n  = 1'b1;
        end
      end
      START_BIT: begin
        if (cnt == CNT_MAX) begin
          state_n = DATA_BITS;
          cnt_n   = '0;
          bitn_n  = '0;
          tx_n    = shreg[0];
          shreg_n = shreg >> 1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA_BITS: begin
        if (cnt == CNT_MAX) begin
          cnt_n = '0;
          if (bitn == 3'd7) begin
            state_n = STOP_BIT;
            tx_n    = 1'b1;
          end else begin
            bitn_n  = bitn + 1'b1;
            tx_n    = shreg[0];
            shreg_n = shreg >> 1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP_BIT: begin
        if (cnt == CNT_MAX) begin
          cnt_n = '0;
          // Last character finished: drop busy and pulse done together.
          if (chr == LAST_CH) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            tx_n    = 1'b1;
          end else begin
            state_n = START_BIT;
            chr_n   = chr + 1'b1;
            shreg_n = enc(cap, chr + 1'b1);
            tx_n    = 1'b0;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hex_uart_dumper.sv
// Scoreboarded bench: stimulus queues expected bytes and done cycles; monitors
// decode the UART line cycle-by-cycle and check done pulses.
module tb_hex_uart_dumper;
  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inp = '0;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  logic        busy0, done0, tx0, busy1, done1, tx1;
  logic        st0, st1, mtx, mdone, mbusy;

  assign st0   = start & ~sel;
  assign st1   = start & sel;
  assign mtx   = sel ? tx1 : tx0;
  assign mdone = sel ? done1 : done0;
  assign mbusy = sel ? busy1 : busy0;

  hex_uart_dumper #(.CLKS_PER_BIT(CPB), .SEND_CRLF(1'b1)) dut (
    .clk(clk), .rst(rst), .inp(inp), .start(st0),
    .busy(busy0), .done(done0), .tx(tx0));

  hex_uart_dumper #(.CLKS_PER_BIT(CPB), .SEND_CRLF(1'b0)) dut8 (
    .clk(clk), .rst(rst), .inp(inp), .start(st1),
    .busy(busy1), .done(done1), .tx(tx1));

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_q[$];
  int         dq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called at a negedge; start is sampled at the following posedge (cycle n).
  task automatic run_line(input logic [31:0] v, input logic [7:0] e[10],
                          input int nch, output int n);
    inp   = v;
    start = 1'b1;
    n     = cyc;
    for (int i = 0; i < nch; i++) sb_q.push_back(e[i]);
    dq.push_back(n + nch * 10 * CPB + 1);
    @(negedge clk);
    start = 1'b0;
    chk("accept_tx", {31'b0, mtx}, 32'd0);
    chk("accept_busy", {31'b0, mbusy}, 32'd1);
  endtask

  // UART monitor: every cycle of a frame must match the expected bit level.
  initial begin : uart_mon
    bit         active;
    bit         bad;
    bit         have;
    int         dcnt;
    logic [7:0] expb;
    logic [7:0] got;
    logic [9:0] fr;
    active = 0; bad = 0; have = 0; dcnt = 0; expb = '0; got = '0; fr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 0;
      end else begin
        if (!active && mtx == 1'b0) begin
          active = 1; dcnt = 0; bad = 0; got = '0;
          have = (sb_q.size() != 0);
          expb = have ? sb_q[0] : 8'h00;
        end
        if (active) begin
          fr = {1'b1, expb, 1'b0};
          if (mtx !== fr[dcnt / 4]) bad = 1;
          if (dcnt % 4 == 2 && dcnt / 4 >= 1 && dcnt / 4 <= 8) got[dcnt / 4 - 1] = mtx;
          if (dcnt == 10 * CPB - 1) begin
            checks++;
            active = 0;
            if (!have) begin
              errors++;
              $display("FAIL uart_unexpected_frame: got %0h expected none (cycle %0d)", got, cyc);
            end else begin
              void'(sb_q.pop_front());
              if (bad) begin
                errors++;
                $display("FAIL uart_frame: got %0h expected %0h (cycle %0d)", got, expb, cyc);
              end
            end
          end
          dcnt++;
        end
      end
    end
  end

  initial begin : done_mon
    int ed;
    forever begin
      @(negedge clk);
      if (!rst && mdone) begin
        checks++;
        if (dq.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: got pulse at %0d expected none", cyc);
        end else begin
          ed = dq.pop_front();
          if (ed != cyc) begin
            errors++;
            $display("FAIL done_cycle: got %0d expected %0d", cyc, ed);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] e[10];
    int n, n2;
    int offs[4];
    offs = '{5, 50, 200, 399};

    repeat (2) @(negedge clk);
    chk("rst_tx0", {31'b0, tx0}, 32'd1);
    chk("rst_busy0", {31'b0, busy0}, 32'd0);
    chk("rst_done0", {31'b0, done0}, 32'd0);
    chk("rst_tx1", {31'b0, tx1}, 32'd1);
    chk("rst_busy1", {31'b0, busy1}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: 0x0000001B with CR LF
    e = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h31, 8'h42, 8'h0D, 8'h0A};
    run_line(32'h0000001B, e, 10, n);
    wait_to(n + 400); chk("t1_busy_last", {31'b0, mbusy}, 32'd1);
    wait_to(n + 401); chk("t1_busy_end", {31'b0, mbusy}, 32'd0);
    chk("t1_tx_idle", {31'b0, mtx}, 32'd1);
    @(negedge clk);

    // 2: no CR LF instance
    sel = 1'b1;
    e = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h00, 8'h00};
    run_line(32'hDEADBEEF, e, 8, n);
    wait_to(n + 320); chk("t2_busy_last", {31'b0, mbusy}, 32'd1);
    wait_to(n + 321); chk("t2_busy_end", {31'b0, mbusy}, 32'd0);
    @(negedge clk);
    sel = 1'b0;

    // 3: input changes and extra starts while busy are ignored
    e = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h0D, 8'h0A};
    run_line(32'h12345678, e, 10, n);
    inp = 32'hFFFFFFFF;
    foreach (offs[i]) begin
      wait_to(n + offs[i]);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_to(n + 401); chk("t3_busy_end", {31'b0, mbusy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("t3_no_restart", {31'b0, mbusy}, 32'd0);
    chk("t3_tx_idle", {31'b0, mtx}, 32'd1);

    // 4: reset during data bit 3 of char 2 ('F' = 0x46, bit3 = 0)
    e = '{8'h43, 8'h41, 8'h46, 8'h45, 8'h46, 8'h30, 8'h30, 8'h44, 8'h0D, 8'h0A};
    run_line(32'hCAFEF00D, e, 10, n);
    wait_to(n + 98); chk("t4_bit3", {31'b0, mtx}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t4_rst_tx", {31'b0, mtx}, 32'd1);
    chk("t4_rst_busy", {31'b0, mbusy}, 32'd0);
    sb_q.delete();
    dq.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("t4_idle", {31'b0, mbusy}, 32'd0);

    // 5: clean line, then restart in the done cycle with an all-zero word (6)
    e = '{8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h30, 8'h0D, 8'h0A};
    run_line(32'h9ABCDEF0, e, 10, n);
    wait_to(n + 401);
    chk("t5_done", {31'b0, done0}, 32'd1);
    chk("t5_busy", {31'b0, busy0}, 32'd0);
    e = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
    run_line(32'h00000000, e, 10, n2);
    wait_to(n2 + 4); chk("t6_start_len", {31'b0, mtx}, 32'd0);
    wait_to(n2 + 5); chk("t6_bit0", {31'b0, mtx}, 32'd0);
    wait_to(n2 + 401); chk("t6_busy_end", {31'b0, mbusy}, 32'd0);

    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size() + dq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
